cpu_clock_controller: RTL and testbench

//   Replaces the free-running divided CPU clock with a clock-enable scheme on the

---
 rtl/cpu_clock_controller.sv | 153 +++++++++++++++
 tb/tb_cpu_clock_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
// Generates a one-cycle clock-enable for the MIPS pipeline on the single
// board clock. Supports three modes: RUN (one enable every div_value
// cycles), STEP (one enable per debounced button press) and HALT. A
// breakpoint request from the pipeline stops RUN and parks the FSM in BRK.
module cpu_clock_controller #(
    parameter logic [31:0] DEFAULT_DIV     = 32'd100_000_000,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [31:0] cfg_div,
    input  logic [1:0]  mode_sel,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [31:0] div_value,
    output logic [31:0] ce_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } state_e;

    state_e      state_q;
    logic        cpu_ce_q;
    logic [31:0] div_q;
    logic [31:0] div_cnt_q;
    logic [31:0] ce_count_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        db_level_q;
    logic [31:0] db_cnt_q;
    logic        step_req_q;
    logic        ce_d;

    // Mode decode used when leaving HALT, STEP or BRK; 11 behaves as HALT.
    function automatic state_e mode_target(input logic [1:0] mode);
        case (mode)
            2'b01:   mode_target = ST_RUN;
            2'b10:   mode_target = ST_STEP;
            default: mode_target = ST_HALT;
        endcase
    endfunction

    // Synchronise the raw button, debounce it and pulse step_req on a debounced rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= 32'd0;
            step_req_q <= 1'b0;
        end else begin
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DEBOUNCE_CYCLES - 32'd1) begin
                    db_level_q <= sync2_q;
                    db_cnt_q   <= 32'd0;
                    step_req_q <= sync2_q;
                end else begin
                    db_cnt_q   <= db_cnt_q + 32'd1;
                    step_req_q <= 1'b0;
                end
            end else begin
                db_cnt_q   <= 32'd0;
                step_req_q <= 1'b0;
            end
        end
    end

    // Decide whether the next cycle carries a clock-enable pulse.
    always_comb begin
        ce_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!halt_req && (mode_sel == 2'b01) && !cfg_we &&
                    (div_cnt_q == div_q - 32'd1)) begin
                    ce_d = 1'b1;
                end else begin
                    ce_d = 1'b0;
                end
            end
            ST_STEP: begin
                if ((mode_sel == 2'b10) && step_req_q) begin
                    ce_d = 1'b1;
                end else begin
                    ce_d = 1'b0;
                end
            end
            default: ce_d = 1'b0;
        endcase
    end

    // Mode FSM with divide register, divide counter and registered enable/count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HALT;
            cpu_ce_q   <= 1'b0;
            div_q      <= DEFAULT_DIV;
            div_cnt_q  <= 32'd0;
            ce_count_q <= 32'd0;
        end else begin
            cpu_ce_q   <= ce_d;
            ce_count_q <= ce_count_q + {31'd0, ce_d};
            if (cfg_we) begin
                div_q <= (cfg_div == 32'd0) ? 32'd1 : cfg_div;
            end
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_q   <= ST_BRK;
                        div_cnt_q <= 32'd0;
                    end else if (mode_sel != 2'b01) begin
                        state_q   <= mode_target(mode_sel);
                        div_cnt_q <= 32'd0;
                    end else if (cfg_we || ce_d) begin
                        div_cnt_q <= 32'd0;
                    end else begin
                        div_cnt_q <= div_cnt_q + 32'd1;
                    end
                end
                ST_BRK: begin
                    // Resuming requires leaving RUN on mode_sel first.
                    if (mode_sel != 2'b01) begin
                        state_q <= mode_target(mode_sel);
                    end
                    div_cnt_q <= 32'd0;
                end
                ST_HALT, ST_STEP: begin
                    state_q   <= mode_target(mode_sel);
                    div_cnt_q <= 32'd0;
                end
                default: begin
                    state_q   <= ST_HALT;
                    div_cnt_q <= 32'd0;
                end
            endcase
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign state     = state_q;
    assign div_value = div_q;
    assign ce_count  = ce_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with a small divide ratio and
// short debounce window so multi-cycle behaviour fits in a few hundred cycles.
module tb_cpu_clock_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [31:0] cfg_div;
    logic [1:0]  mode_sel;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [31:0] div_value;
    logic [31:0] ce_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] div;
        logic [1:0]  mode;
        logic        halt;
        logic        ce;
        logic [1:0]  st;
        logic [31:0] dv;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    cpu_clock_controller #(
        .DEFAULT_DIV    (32'd4),
        .DEBOUNCE_CYCLES(32'd8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_div  (cfg_div),
        .mode_sel (mode_sel),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .state    (state),
        .div_value(div_value),
        .ce_count (ce_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] div, input logic [1:0] mode,
                       input logic halt, input logic ce, input logic [1:0] st,
                       input logic [31:0] dv, input logic [31:0] cnt);
        vec_t v;
        v.we = we; v.div = div; v.mode = mode; v.halt = halt;
        v.ce = ce; v.st = st; v.dv = dv; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Run n cycles, sampling on negedge; report pulse count and first pulse index (1-based).
    task automatic watch(input int n, output int pulses, output int first_pos);
        pulses = 0;
        first_pos = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) begin
                pulses++;
                if (first_pos == 0) first_pos = k;
            end
        end
    endtask

    initial begin
        int p;
        int pos;
        int total;

        reset = 1'b0; cfg_we = 1'b0; cfg_div = 32'd0; mode_sel = 2'b00;
        step_btn = 1'b0; halt_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_ce", {31'd0, cpu_ce}, 32'd0);
        check("reset_div", div_value, 32'd4);
        check("reset_count", ce_count, 32'd0);
        reset = 1'b1;

        // RUN with div 4: pulses on edges 4, 8, 12 after entering RUN
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b0, 2'b01, 32'd4, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            add(1'b0, 32'd0, 2'b01, 1'b0, (i % 4 == 0), 2'b01, 32'd4, 32'(i / 4));
        end
        // cfg_div=0 clamps to 1, then enable every cycle
        add(1'b1, 32'd0, 2'b01, 1'b0, 1'b0, 2'b01, 32'd1, 32'd3);
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 2'b01, 32'd1, 32'd4);
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 2'b01, 32'd1, 32'd5);
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 2'b01, 32'd1, 32'd6);
        // back to div 4, breakpoint on the tick cycle
        add(1'b1, 32'd4, 2'b01, 1'b0, 1'b0, 2'b01, 32'd4, 32'd6);
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 32'd0, 2'b01, 1'b0, 1'b0, 2'b01, 32'd4, 32'd6);
        end
        add(1'b0, 32'd0, 2'b01, 1'b1, 1'b0, 2'b11, 32'd4, 32'd6);
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b0, 2'b11, 32'd4, 32'd6);
        add(1'b0, 32'd0, 2'b01, 1'b1, 1'b0, 2'b11, 32'd4, 32'd6);
        add(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 32'd4, 32'd6);
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b0, 2'b01, 32'd4, 32'd6);
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 32'd0, 2'b01, 1'b0, 1'b0, 2'b01, 32'd4, 32'd6);
        end
        add(1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 2'b01, 32'd4, 32'd7);
        // halt_req ignored outside RUN, HALT/STEP mode changes
        add(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 32'd4, 32'd7);
        add(1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 2'b00, 32'd4, 32'd7);
        add(1'b0, 32'd0, 2'b10, 1'b0, 1'b0, 2'b10, 32'd4, 32'd7);
        add(1'b0, 32'd0, 2'b11, 1'b0, 1'b0, 2'b00, 32'd4, 32'd7);

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_we = vecs[i].we; cfg_div = vecs[i].div;
            mode_sel = vecs[i].mode; halt_req = vecs[i].halt;
            @(negedge clk);
            check($sformatf("vec%0d_ce", i), {31'd0, cpu_ce}, {31'd0, vecs[i].ce});
            check($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
            check($sformatf("vec%0d_div", i), div_value, vecs[i].dv);
            check($sformatf("vec%0d_count", i), ce_count, vecs[i].cnt);
        end
        cfg_we = 1'b0; halt_req = 1'b0;

        // mode 11: button press is discarded, no pulse even after entering STEP
        mode_sel = 2'b11;
        step_btn = 1'b1;
        watch(20, p, pos);
        total = p;
        check("mode11_state", {30'd0, state}, 32'd0);
        mode_sel = 2'b10;
        watch(5, p, pos);
        total += p;
        step_btn = 1'b0;
        watch(20, p, pos);
        total += p;
        check("discarded_step_pulses", total, 32'd0);
        check("step_state", {30'd0, state}, 32'd2);
        check("discarded_count", ce_count, 32'd7);

        // STEP with bouncing button, then a clean hold
        total = 0;
        for (int b = 0; b < 2; b++) begin
            step_btn = 1'b1;
            watch(3, p, pos);
            total += p;
            step_btn = 1'b0;
            watch(3, p, pos);
            total += p;
        end
        check("bounce_pulses", total, 32'd0);
        step_btn = 1'b1;
        watch(20, p, pos);
        check("press1_pulses", p, 32'd1);
        check("press1_pos", pos, 32'd11);
        check("press1_count", ce_count, 32'd8);
        step_btn = 1'b0;
        watch(20, p, pos);
        check("release_pulses", p, 32'd0);
        step_btn = 1'b1;
        watch(20, p, pos);
        check("press2_pulses", p, 32'd1);
        check("press2_pos", pos, 32'd11);
        check("press2_count", ce_count, 32'd9);

        // reset in the middle of RUN with div 1 (cpu_ce high)
        cfg_we = 1'b1; cfg_div = 32'd1; mode_sel = 2'b01;
        @(negedge clk);
        cfg_we = 1'b0;
        repeat (3) @(negedge clk);
        check("prereset_ce", {31'd0, cpu_ce}, 32'd1);
        check("prereset_div", div_value, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset_state", {30'd0, state}, 32'd0);
        check("midreset_ce", {31'd0, cpu_ce}, 32'd0);
        check("midreset_div", div_value, 32'd4);
        check("midreset_count", ce_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        // after release with mode 01, first pulse after 4 cycles of RUN
        watch(5, p, pos);
        check("post_reset_pos", pos, 32'd5);
        check("post_reset_count", ce_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
